// File: rtl/trigger_pkg.sv
// Shared types and helpers for the trigger monitor.
// State encoding and a saturating increment.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } trig_mon_state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (v >= m) ? m : v + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment.
import trigger_pkg::*;

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), W));
    end
  end

endmodule

// File: rtl/trigger_monitor.sv
// Receive-side period checker for a one-cycle periodic trigger.
// Locks after LOCK_COUNT matching intervals, flags early/missing pulses.
import trigger_pkg::*;

module trigger_monitor #(
  parameter int N          = 2,
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 4,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             clear,
  output logic             locked,
  output logic             period_err,
  output logic [CNT_W-1:0] period,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] N_V  = CNT_W'(N);
  localparam logic [CNT_W-1:0] N_M1 = CNT_W'(N - 1);
  localparam logic [MW-1:0]    LC_V = MW'(LOCK_COUNT);

  trig_mon_state_t state;
  trig_mon_state_t state_nxt;
  logic [MW-1:0]   match_cnt;
  logic [MW-1:0]   match_nxt;
  logic [MW-1:0]   match_inc;
  logic [CNT_W-1:0] ival;
  logic [CNT_W-1:0] measured;
  logic             ival_sat;
  logic             hit;
  logic             err;

  // ival restarts on every event so it always holds cycles since the last one
  sat_counter #(.W(CNT_W)) u_ival (
    .clk (clk),
    .rst (rst),
    .clr (clear | trigger),
    .inc (1'b1),
    .q   (ival)
  );

  sat_counter #(.W(ERR_W)) u_err (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (err),
    .q   (err_cnt)
  );

  assign measured  = CNT_W'(sat_inc(32'(ival), CNT_W));
  assign ival_sat  = &ival;
  assign hit       = (measured == N_V);
  assign match_inc = match_cnt + MW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    if (clear) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state_nxt = ACQUIRE;
            match_nxt = '0;
          end
        end
        ACQUIRE: begin
          if (trigger && hit) begin
            match_nxt = match_inc;
            if (match_inc == LC_V) state_nxt = LOCKED;
          end else if (trigger) begin
            match_nxt = '0;
          end else if (ival_sat) begin
            state_nxt = IDLE;
          end
        end
        LOCKED: begin
          if (trigger && !hit) begin
            state_nxt = ACQUIRE;
            match_nxt = '0;
          end else if (!trigger && ival == N_M1) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
    err    = 1'b0;
    if (!clear && state == LOCKED) begin
      err = trigger ? !hit : (ival == N_M1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period     <= '0;
      period_err <= 1'b0;
    end else if (clear) begin
      period     <= '0;
      period_err <= 1'b0;
    end else begin
      period_err <= err;
      if (trigger) period <= measured;
    end
  end

endmodule

// File: tb/tb_trigger_monitor.sv
// Self-checking bench: three monitors with different N share one trigger
// wire and are compared against a timestamp-based reference model.
module tb_trigger_monitor;
  import trigger_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trigger = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic       lk0, pe0, lk1, pe1, lk2, pe2;
  logic [7:0] pd0, pd1, pd2;
  logic [3:0] ec0, ec2;
  logic [1:0] ec1;
  logic [15:0] obs [3];

  trigger_monitor #(.N(2), .CNT_W(8), .ERR_W(4), .LOCK_COUNT(2)) u0 (
    .clk(clk), .rst(rst), .trigger(trigger), .clear(clear),
    .locked(lk0), .period_err(pe0), .period(pd0), .err_cnt(ec0));
  trigger_monitor #(.N(4), .CNT_W(8), .ERR_W(2), .LOCK_COUNT(2)) u1 (
    .clk(clk), .rst(rst), .trigger(trigger), .clear(clear),
    .locked(lk1), .period_err(pe1), .period(pd1), .err_cnt(ec1));
  trigger_monitor #(.N(1), .CNT_W(8), .ERR_W(4), .LOCK_COUNT(2)) u2 (
    .clk(clk), .rst(rst), .trigger(trigger), .clear(clear),
    .locked(lk2), .period_err(pe2), .period(pd2), .err_cnt(ec2));

  assign obs[0] = {lk0, pe0, 2'b00, pd0, ec0};
  assign obs[1] = {lk1, pe1, 2'b00, pd1, 2'b00, ec1};
  assign obs[2] = {lk2, pe2, 2'b00, pd2, ec2};

  int checks = 0;
  int errors = 0;

  // Model: an interval is the number of edges since the last event/clear/reset.
  typedef struct {
    int n; int lc; int cmax; int emax;
    int ref_c; int mode; int streak;
    int period; int err_cnt; bit perr;
  } mdl_t;
  mdl_t m [3];
  int cyc = 0;

  task automatic mreset(input int i);
    m[i].mode = 0; m[i].ref_c = cyc; m[i].streak = 0;
    m[i].period = 0; m[i].err_cnt = 0; m[i].perr = 1'b0;
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) mreset(i);
  endtask

  task automatic mstep(input int i, input bit t, input bit c);
    int el, meas;
    bit e;
    if (c) begin
      mreset(i);
      return;
    end
    el = cyc - m[i].ref_c;
    meas = (el > m[i].cmax) ? m[i].cmax : el;
    e = 1'b0;
    if (t) begin
      m[i].period = meas;
      m[i].ref_c = cyc;
      if (m[i].mode == 0) begin
        m[i].mode = 1; m[i].streak = 0;
      end else if (m[i].mode == 1) begin
        if (meas == m[i].n) begin
          m[i].streak++;
          if (m[i].streak == m[i].lc) m[i].mode = 2;
        end else m[i].streak = 0;
      end else if (meas != m[i].n) begin
        e = 1'b1; m[i].mode = 1; m[i].streak = 0;
      end
    end else begin
      if (m[i].mode == 1 && el - 1 >= m[i].cmax) m[i].mode = 0;
      else if (m[i].mode == 2 && el == m[i].n) begin
        e = 1'b1; m[i].mode = 0;
      end
    end
    m[i].perr = e;
    if (e && m[i].err_cnt < m[i].emax) m[i].err_cnt++;
  endtask

  function automatic logic [15:0] expv(input int i);
    logic [15:0] v;
    v = '0;
    v[15] = (m[i].mode == 2);
    v[14] = m[i].perr;
    v[11:4] = 8'(m[i].period);
    v[3:0] = 4'(m[i].err_cnt);
    return v;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input bit t, input bit c);
    trigger = t;
    clear = c;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) mstep(i, t, c);
    @(negedge clk);
  endtask

  task automatic gap_event(input int g);
    for (int k = 1; k < g; k++) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    m[0].n = 2; m[0].lc = 2; m[0].cmax = 255; m[0].emax = 15;
    m[1].n = 4; m[1].lc = 2; m[1].cmax = 255; m[1].emax = 3;
    m[2].n = 1; m[2].lc = 2; m[2].cmax = 255; m[2].emax = 15;
    reset_models();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset u%0d: got %h expected 0000", i, obs[i]);
      end
    end
    rst = 1'b1;
    reset_models();
  endtask

  task automatic test_lock();
    for (int k = 0; k < 5; k++) begin
      drive(k % 2 == 0, 1'b0);
      if (k == 2) begin
        checks++;
        if (lk0 !== 1'b0) begin
          errors++;
          $display("FAIL lock_early: got %b expected 0", lk0);
        end
      end
    end
    checks++;
    if ({lk0, pd0, ec0} !== {1'b1, 8'd2, 4'd0}) begin
      errors++;
      $display("FAIL lock: got lk=%b pd=%0d ec=%0d expected 1/2/0",
               lk0, pd0, ec0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== expv(i)) begin
        errors++;
        $display("FAIL lock_model u%0d: got %h expected %h",
                 i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_missing();
    int pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0);
      if (pe0 === 1'b1) pulses++;
      if (k == 1) begin
        checks++;
        if (pe0 !== 1'b1 || lk0 !== 1'b0) begin
          errors++;
          $display("FAIL miss_due: got pe=%b lk=%b expected 1/0", pe0, lk0);
        end
      end
    end
    checks++;
    if (pulses != 1 || ec0 !== 4'd1 || u0.state !== IDLE) begin
      errors++;
      $display("FAIL miss: got pulses=%0d ec=%0d st=%0d expected 1/1/0",
               pulses, ec0, u0.state);
    end
  endtask

  task automatic test_early();
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    gap_event(4);
    gap_event(4);
    checks++;
    if (lk1 !== 1'b1) begin
      errors++;
      $display("FAIL early_lock: got %b expected 1", lk1);
    end
    gap_event(2);
    checks++;
    if ({pd1, pe1, lk1} !== {8'd2, 1'b1, 1'b0} || u1.state !== ACQUIRE) begin
      errors++;
      $display("FAIL early: got pd=%0d pe=%b lk=%b st=%0d expected 2/1/0/1",
               pd1, pe1, lk1, u1.state);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (pe1 !== 1'b0) begin
      errors++;
      $display("FAIL early_pulse_len: got %b expected 0", pe1);
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    checks++;
    if (lk1 !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: got %b expected 0", lk1);
    end
    gap_event(4);
    checks++;
    if (lk1 !== 1'b1 || ec1 !== 2'd1) begin
      errors++;
      $display("FAIL relock: got lk=%b ec=%0d expected 1/1", lk1, ec1);
    end
  endtask

  task automatic test_clear_event();
    drive(1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      repeat (3) gap_event(2);
      repeat (4) drive(1'b0, 1'b0);
    end
    repeat (3) gap_event(2);
    checks++;
    if (lk0 !== 1'b1 || ec0 !== 4'd3) begin
      errors++;
      $display("FAIL pre_clear: got lk=%b ec=%0d expected 1/3", lk0, ec0);
    end
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    checks++;
    if ({lk0, pe0, pd0, ec0} !== 14'h0) begin
      errors++;
      $display("FAIL clear_event: got lk=%b pe=%b pd=%0d ec=%0d expected 0",
               lk0, pe0, pd0, ec0);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (pe0 !== 1'b0 || obs[0] !== expv(0)) begin
      errors++;
      $display("FAIL post_clear: got %h expected %h", obs[0], expv(0));
    end
  endtask

  task automatic test_saturation();
    int e;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      gap_event(4);
      gap_event(4);
      gap_event(2);
      e = (j + 1 > 3) ? 3 : j + 1;
      checks++;
      if (ec1 !== 2'(e) || pe1 !== 1'b1) begin
        errors++;
        $display("FAIL err_sat %0d: got ec=%0d pe=%b expected %0d/1",
                 j, ec1, pe1, e);
      end
    end
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    gap_event(300);
    checks++;
    if (pd0 !== 8'd255 || pd1 !== 8'd255) begin
      errors++;
      $display("FAIL period_sat: got %0d/%0d expected 255", pd0, pd1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== expv(i)) begin
        errors++;
        $display("FAIL sat_model u%0d: got %h expected %h",
                 i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1);
    repeat (3) gap_event(2);
    checks++;
    if (lk0 !== 1'b1) begin
      errors++;
      $display("FAIL async_prelock: got %b expected 1", lk0);
    end
    trigger = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 16'h0) begin
        errors++;
        $display("FAIL async_reset u%0d: got %h expected 0000", i, obs[i]);
      end
    end
    reset_models();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    reset_models();
  endtask

  task automatic test_n1();
    drive(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (lk2 !== (k >= 2) || pd2 !== 8'd1) begin
        errors++;
        $display("FAIL n1 k=%0d: got lk=%b pd=%0d expected %b/1",
                 k, lk2, pd2, k >= 2);
      end
    end
    drive(1'b0, 1'b0);
    checks++;
    if (pe2 !== 1'b1 || lk2 !== 1'b0 || ec2 !== 4'd1) begin
      errors++;
      $display("FAIL n1_miss: got pe=%b lk=%b ec=%0d expected 1/0/1",
               pe2, lk2, ec2);
    end
  endtask

  task automatic test_random();
    int g = 2;
    int ph = 0;
    drive(1'b0, 1'b1);
    for (int k = 0; k < 1500; k++) begin
      bit t;
      bit c;
      if (k % 40 == 0) g = $urandom_range(1, 5);
      t = (ph == 0);
      if ($urandom_range(0, 19) == 0) t = !t;
      ph = (ph + 1 >= g) ? 0 : ph + 1;
      c = ($urandom_range(0, 299) == 0);
      drive(t, c);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== expv(i)) begin
          errors++;
          $display("FAIL random u%0d cyc %0d: got %h expected %h",
                   i, cyc, obs[i], expv(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_missing();
    test_early();
    test_clear_event();
    test_saturation();
    test_async_reset();
    test_n1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
